// File: rtl/operand_fetch_stage_pkg.sv
// Shared CPU definitions for the operand-fetch slice.
//  rfNum       : number of architectural GPRs (r0 hardwired to zero)
//  PAYLOAD_W   : width of the opaque decoded-control payload
//  Gr / DType  : register index and data word types
//  of_ex_bus_t : operand-fetch -> execute pipeline register contents
package cpuDefine;

    localparam int rfNum     = 32;
    localparam int PAYLOAD_W = 64;

    typedef logic [4:0]  Gr;
    typedef logic [31:0] DType;

    typedef struct packed {
        DType                 rj_val;
        DType                 rk_val;
        Gr                    rd;
        logic                 wen;
        logic [PAYLOAD_W-1:0] payload;
    } of_ex_bus_t;

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// rf_scoreboard: per-register pending-write counters.
//  inc_en/inc_rd : an issued instruction will write inc_rd
//  wb_en/wb_rd   : writeback retires a write to wb_rd this cycle
//  fl_en/fl_rd   : a squashed instruction will never write fl_rd
//  q_rj/q_rk     : source lookups -> busy_rj/busy_rk
//  q_rd          : destination lookup -> full_rd (counter at max)
module rf_scoreboard
    import cpuDefine::*;
#(
    parameter int RF_NUM = rfNum,
    parameter int PEND_W = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_en,
    input  Gr    inc_rd,
    input  logic wb_en,
    input  Gr    wb_rd,
    input  logic fl_en,
    input  Gr    fl_rd,
    input  Gr    q_rj,
    input  Gr    q_rk,
    input  Gr    q_rd,
    output logic busy_rj,
    output logic busy_rk,
    output logic full_rd
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [RF_NUM-1:0][PEND_W-1:0] pend_q, pend_d;
    logic [RF_NUM-1:0]             uflow;

    // Net counter update: +inc, -wb, -flush. Returns {underflow, next}.
    function automatic logic [PEND_W:0] step(input logic [PEND_W-1:0] cur,
                                             input logic inc,
                                             input logic [1:0] dn);
        logic [PEND_W+1:0] up, dn_w, res;
        up   = {2'b00, cur} + (PEND_W+2)'(inc);
        dn_w = (PEND_W+2)'(dn);
        res  = up - dn_w;
        if (up < dn_w) step = {1'b1, {PEND_W{1'b0}}};
        else           step = {1'b0, res[PEND_W-1:0]};
    endfunction

    // A register retiring its last pending write this cycle is readable
    // through the regfile bypass, so it does not count as busy.
    function automatic logic busy(input Gr r);
        busy = (r != '0) && (pend_q[r] != '0) &&
               !(wb_en && (wb_rd == r) && (pend_q[r] == PEND_ONE));
    endfunction

    always_comb begin
        pend_d = pend_q;
        uflow  = '0;
        for (int r = 1; r < RF_NUM; r++) begin
            logic [1:0]      dn;
            logic [PEND_W:0] s;
            dn = {1'b0, (wb_en && (wb_rd == Gr'(r)))} +
                 {1'b0, (fl_en && (fl_rd == Gr'(r)))};
            s  = step(pend_q[r], inc_en && (inc_rd == Gr'(r)), dn);
            uflow[r]  = s[PEND_W];
            pend_d[r] = s[PEND_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign busy_rj = busy(q_rj);
    assign busy_rk = busy(q_rk);
    assign full_rd = (q_rd != '0) && (pend_q[q_rd] == PEND_MAX);

    // Retiring a write that was never issued is a protocol error.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) uflow == '0);

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: register-read / issue stage between decode and execute.
//  Decode side  : id_valid/id_ready handshake, source/dest indices, payload
//  Regfile side : rf_*_idx read indices (straight from decode), rf_*_data
//  Writeback    : wb_en/wb_rd retire pending writes in the scoreboard
//  Execute side : ex_valid/ex_ready handshake, captured operands and control
//  flush        : squashes the output-register instruction and blocks issue
module operand_fetch_stage
    import cpuDefine::*;
#(
    parameter int RF_NUM = rfNum,
    parameter int PEND_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  Gr                    id_rj,
    input  Gr                    id_rk,
    input  Gr                    id_rd,
    input  logic                 id_use_rj,
    input  logic                 id_use_rk,
    input  logic                 id_wen,
    input  logic [PAYLOAD_W-1:0] id_payload,
    output Gr                    rf_rj_idx,
    output Gr                    rf_rk_idx,
    input  DType                 rf_rj_data,
    input  DType                 rf_rk_data,
    input  logic                 wb_en,
    input  Gr                    wb_rd,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output DType                 ex_rj_val,
    output DType                 ex_rk_val,
    output Gr                    ex_rd,
    output logic                 ex_wen,
    output logic [PAYLOAD_W-1:0] ex_payload
);

    logic       ex_valid_q, ex_valid_d;
    of_ex_bus_t ex_q, ex_d;
    logic       busy_rj, busy_rk, full_rd;
    logic       src_rj, src_rk, hazard, accept;

    assign rf_rj_idx = id_rj;
    assign rf_rk_idx = id_rk;

    assign src_rj = id_use_rj && (id_rj != '0);
    assign src_rk = id_use_rk && (id_rk != '0);

    // A writer whose destination counter is saturated must wait, otherwise
    // the counter would wrap and lose track of in-flight writes.
    assign hazard   = (src_rj && busy_rj) || (src_rk && busy_rk) ||
                      (id_wen && full_rd);
    assign id_ready = !flush && !hazard && (!ex_valid_q || ex_ready);
    assign accept   = id_valid && id_ready;

    rf_scoreboard #(
        .RF_NUM (RF_NUM),
        .PEND_W (PEND_W)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .inc_en  (accept && id_wen && (id_rd != '0)),
        .inc_rd  (id_rd),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .fl_en   (flush && ex_valid_q && ex_q.wen && (ex_q.rd != '0)),
        .fl_rd   (ex_q.rd),
        .q_rj    (id_rj),
        .q_rk    (id_rk),
        .q_rd    (id_rd),
        .busy_rj (busy_rj),
        .busy_rk (busy_rk),
        .full_rd (full_rd)
    );

    // flush beats accept; accept beats drain; otherwise hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_d       = '0;
        end else if (accept) begin
            ex_valid_d     = 1'b1;
            ex_d.rj_val    = src_rj ? rf_rj_data : '0;
            ex_d.rk_val    = src_rk ? rf_rk_data : '0;
            ex_d.rd        = id_rd;
            ex_d.wen       = id_wen;
            ex_d.payload   = id_payload;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
            ex_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_rj_val  = ex_q.rj_val;
    assign ex_rk_val  = ex_q.rk_val;
    assign ex_rd      = ex_q.rd;
    assign ex_wen     = ex_q.wen;
    assign ex_payload = ex_q.payload;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;
    import cpuDefine::*;

    logic                 clk = 1'b0;
    logic                 reset, flush, id_valid, id_ready;
    Gr                    id_rj, id_rk, id_rd, rf_rj_idx, rf_rk_idx, wb_rd, ex_rd;
    logic                 id_use_rj, id_use_rk, id_wen, wb_en, ex_valid, ex_ready, ex_wen;
    logic [PAYLOAD_W-1:0] id_payload, ex_payload;
    DType                 rf_rj_data, rf_rk_data, ex_rj_val, ex_rk_val;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_rj      (id_rj),
        .id_rk      (id_rk),
        .id_rd      (id_rd),
        .id_use_rj  (id_use_rj),
        .id_use_rk  (id_use_rk),
        .id_wen     (id_wen),
        .id_payload (id_payload),
        .rf_rj_idx  (rf_rj_idx),
        .rf_rk_idx  (rf_rk_idx),
        .rf_rj_data (rf_rj_data),
        .rf_rk_data (rf_rk_data),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rj_val  (ex_rj_val),
        .ex_rk_val  (ex_rk_val),
        .ex_rd      (ex_rd),
        .ex_wen     (ex_wen),
        .ex_payload (ex_payload)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pend(input int r);
        return dut.u_sb.pend_q[r];
    endfunction

    task automatic drv(input logic v, input Gr rj, input Gr rk, input Gr rd,
                       input logic urj, input logic urk, input logic wen,
                       input logic [63:0] pl, input DType dj, input DType dk);
        id_valid = v;   id_rj = rj;   id_rk = rk;   id_rd = rd;
        id_use_rj = urj; id_use_rk = urk; id_wen = wen; id_payload = pl;
        rf_rj_data = dj; rf_rk_data = dk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; ex_ready = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0);
        #12;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_rj", ex_rj_val, 0);
        chk("rst_ex_payload", ex_payload, 0);
        chk("rst_pend_all", dut.u_sb.pend_q, 0);
        chk("rst_id_ready", id_ready, 1);
        reset = 1'b0;
        tick();

        // 1: add r3 <- r1, r2
        ex_ready = 1'b1;
        drv(1, 1, 2, 3, 1, 1, 1, 64'hA5, 5, 7);
        #1;
        chk("t1_id_ready", id_ready, 1);
        chk("t1_rf_rj_idx", rf_rj_idx, 1);
        chk("t1_rf_rk_idx", rf_rk_idx, 2);
        tick();
        chk("t1_ex_valid", ex_valid, 1);
        chk("t1_ex_rj", ex_rj_val, 5);
        chk("t1_ex_rk", ex_rk_val, 7);
        chk("t1_ex_rd", ex_rd, 3);
        chk("t1_ex_wen", ex_wen, 1);
        chk("t1_ex_payload", ex_payload, 64'hA5);
        chk("t1_pend3", pend(3), 1);
        id_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd3;
        tick();
        wb_en = 1'b0;
        chk("t1_drain_valid", ex_valid, 0);
        chk("t1_pend3_wb", pend(3), 0);

        // 2: RAW on r4, released by the writeback bypass
        drv(1, 0, 0, 4, 0, 0, 1, 64'h4, 0, 0);
        tick();
        chk("t2_pend4", pend(4), 1);
        drv(1, 4, 0, 0, 1, 0, 0, 64'h40, 32'h111, 32'h999);
        #1;
        chk("t2_stall0", id_ready, 0);
        tick();
        chk("t2_stall_ex_valid", ex_valid, 0);
        chk("t2_stall1", id_ready, 0);
        tick();
        wb_en = 1'b1; wb_rd = 5'd4; rf_rj_data = 32'h44;
        #1;
        chk("t2_wb_ready", id_ready, 1);
        tick();
        wb_en = 1'b0;
        chk("t2_ex_valid", ex_valid, 1);
        chk("t2_ex_rj_bypass", ex_rj_val, 32'h44);
        chk("t2_ex_rk_unused", ex_rk_val, 0);
        chk("t2_ex_payload", ex_payload, 64'h40);
        chk("t2_pend4_wb", pend(4), 0);

        // 3: writer of r6 issues in the same cycle r6 writes back
        drv(1, 0, 0, 6, 0, 0, 1, 64'h6, 0, 0);
        tick();
        chk("t3_pend6_a", pend(6), 1);
        wb_en = 1'b1; wb_rd = 5'd6;
        #1;
        chk("t3_no_stall", id_ready, 1);
        tick();
        wb_en = 1'b0;
        chk("t3_pend6_net", pend(6), 1);
        chk("t3_ex_valid", ex_valid, 1);
        id_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd6;
        tick();
        wb_en = 1'b0;
        chk("t3_pend6_clr", pend(6), 0);

        // 4: saturated counter on r7 blocks a fourth writer
        drv(1, 0, 0, 7, 0, 0, 1, 64'h7, 0, 0);
        tick(); tick(); tick();
        chk("t4_pend7_max", pend(7), 3);
        #1;
        chk("t4_full_stall", id_ready, 0);
        wb_en = 1'b1; wb_rd = 5'd7;
        #1;
        chk("t4_full_stall_wb", id_ready, 0);
        tick();
        wb_en = 1'b0;
        chk("t4_pend7_dec", pend(7), 2);
        chk("t4_drain", ex_valid, 0);
        #1;
        chk("t4_release", id_ready, 1);
        tick();
        chk("t4_pend7_refill", pend(7), 3);
        chk("t4_ex_valid", ex_valid, 1);
        id_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd7;
        tick(); tick(); tick();
        wb_en = 1'b0;
        chk("t4_pend7_clr", pend(7), 0);

        // 5: back-pressure then back-to-back transfer; r0 operands read as 0
        drv(1, 1, 2, 0, 1, 1, 0, 64'h55, 11, 22);
        tick();
        chk("t5_a_valid", ex_valid, 1);
        chk("t5_a_rj", ex_rj_val, 11);
        ex_ready = 1'b0;
        drv(1, 1, 2, 0, 1, 1, 0, 64'h66, 33, 44);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_bp_ready", id_ready, 0);
            tick();
            chk("t5_bp_valid", ex_valid, 1);
            chk("t5_bp_rj", ex_rj_val, 11);
            chk("t5_bp_payload", ex_payload, 64'h55);
        end
        ex_ready = 1'b1;
        #1;
        chk("t5_resume_ready", id_ready, 1);
        tick();
        chk("t5_b_valid", ex_valid, 1);
        chk("t5_b_rj", ex_rj_val, 33);
        chk("t5_b_rk", ex_rk_val, 44);
        chk("t5_b_payload", ex_payload, 64'h66);
        drv(1, 0, 0, 0, 1, 1, 0, 64'h77, 32'hDEAD, 32'hBEEF);
        tick();
        chk("t5_r0_rj", ex_rj_val, 0);
        chk("t5_r0_rk", ex_rk_val, 0);
        id_valid = 1'b0;
        tick();
        chk("t5_idle", ex_valid, 0);

        // 6: flush a held writer of r9 while decode offers a writer of r10
        drv(1, 0, 0, 9, 0, 0, 1, 64'h9, 0, 0);
        tick();
        chk("t6_pend9", pend(9), 1);
        ex_ready = 1'b0; flush = 1'b1;
        drv(1, 0, 0, 10, 0, 0, 1, 64'hA, 0, 0);
        #1;
        chk("t6_flush_ready", id_ready, 0);
        tick();
        flush = 1'b0; id_valid = 1'b0;
        chk("t6_flush_valid", ex_valid, 0);
        chk("t6_pend9_flushed", pend(9), 0);
        chk("t6_pend10_none", pend(10), 0);

        // reset while a reader of r12 is stalled
        drv(1, 0, 0, 12, 0, 0, 1, 64'hC, 0, 0);
        tick();
        chk("t7_pend12", pend(12), 1);
        drv(1, 12, 0, 0, 1, 0, 0, 64'hD, 0, 0);
        #1;
        chk("t7_stall", id_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_rst_valid", ex_valid, 0);
        chk("t7_rst_pend", dut.u_sb.pend_q, 0);
        chk("t7_rst_payload", ex_payload, 0);
        id_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("t7_post_valid", ex_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
